// File: rtl/led_pulse_display.sv
// led_pulse_display: turns clean event pulses into visible LED flashes.
// Each rising edge on pulse_in queues one flash (ON_CYCLES lit, OFF_CYCLES
// dark). Events arriving mid-flash wait in a saturating counter, and queued
// flashes play back to back with no idle cycle between them.
module led_pulse_display #(
  parameter int unsigned ON_CYCLES  = 250,
  parameter int unsigned OFF_CYCLES = 250,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned TIMER_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             led_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               pulse_in_d;
  logic               evt;
  logic               start;

  // Rising-edge detect and flash-start decision (start doubles as the
  // pending decrement, so it is only true when something is queued).
  always_comb begin
    evt   = pulse_in & ~pulse_in_d;
    start = (pending != '0) &&
            ((state == ST_IDLE) || ((state == ST_OFF) && (timer == '0)));
  end

  assign busy = (state != ST_IDLE) || (pending != '0);

  // Delay register for edge detect; a level already high out of reset
  // counts as one event because this clears to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pulse_in_d <= 1'b0;
    else     pulse_in_d <= pulse_in;
  end

  // Pending queue: a simultaneous event and start cancel out; an event
  // arriving at saturation is dropped and latched into the sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      unique case ({evt, start})
        2'b10: begin
          if (pending != CNT_MAX) pending  <= pending + 1'b1;
          else                    overflow <= 1'b1;
        end
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  // Flash sequencer; led_out is registered as (next state == ON).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      led_out <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_ON;
            timer   <= ON_LOAD;
            led_out <= 1'b1;
          end
        end
        ST_ON: begin
          if (timer == '0) begin
            state   <= ST_OFF;
            timer   <= OFF_LOAD;
            led_out <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_OFF: begin
          if (timer == '0) begin
            if (start) begin
              state   <= ST_ON;
              timer   <= ON_LOAD;
              led_out <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          timer   <= '0;
          led_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
